bcd_up_counter_2digit: RTL and testbench

Two-digit BCD up-counter (modulo 60, 00→59→00) with an internal 1 Hz tick prescaler and a time-multiplexed seven-segment driver for the board's 4-digit display. It is the count-up counterpart of the team's single-digit down-counter and shares its segment encoding and display-control conventions. All logic runs in the single `f` clock domain. The prescaler and scan dividers generate one-cycle enables, not derived clocks. It serves as the seconds stage of stopwatch/clock labs; `carry` chains to a minutes stage.

---
 rtl/bcd_up_counter_2digit.sv | 105 ++++++++++
 tb/tb_bcd_up_counter_2digit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bcd_up_counter_2digit.sv
// Seconds stage: modulo-60 BCD up-counter on a prescaled tick, with a two-digit
// multiplexed seven-segment driver for the board's 4-digit display.
module bcd_up_counter_2digit #(
    parameter int unsigned DIV_1HZ  = 50000000,
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic       f,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       carry,
    output logic [3:0] B,
    output logic [7:0] D_ssd
);

    localparam int unsigned PW = (DIV_1HZ  > 1) ? $clog2(DIV_1HZ)  : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PW-1:0] P_LAST = PW'(DIV_1HZ - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);

    logic [PW-1:0] pcnt;
    logic [SW-1:0] scnt;
    logic          sel;
    logic          tick;
    logic [3:0]    digit;

    assign tick = en && (pcnt == P_LAST);

    // Prescaler and counter; clr wins over tick and en, and never raises carry.
    always_ff @(posedge f or negedge rst_n) begin
        if (!rst_n) begin
            pcnt  <= '0;
            ones  <= 4'd0;
            tens  <= 4'd0;
            carry <= 1'b0;
        end else if (clr) begin
            pcnt  <= '0;
            ones  <= 4'd0;
            tens  <= 4'd0;
            carry <= 1'b0;
        end else begin
            carry <= 1'b0;
            if (en) begin
                if (tick) begin
                    pcnt <= '0;
                end else begin
                    pcnt <= pcnt + 1'b1;
                end
            end
            if (tick) begin
                if (ones < 4'd9) begin
                    ones <= ones + 4'd1;
                end else begin
                    ones <= 4'd0;
                    if (tens < 4'd5) begin
                        tens <= tens + 4'd1;
                    end else begin
                        tens  <= 4'd0;
                        carry <= 1'b1;
                    end
                end
            end
        end
    end

    // Scan timing free-runs so the display keeps refreshing while counting is held.
    always_ff @(posedge f or negedge rst_n) begin
        if (!rst_n) begin
            scnt <= '0;
            sel  <= 1'b0;
        end else if (scnt == S_LAST) begin
            scnt <= '0;
            sel  <= ~sel;
        end else begin
            scnt <= scnt + 1'b1;
        end
    end

    always_comb begin
        B     = sel ? 4'b1101 : 4'b1110;
        digit = sel ? tens : ones;
    end

    // Active-low {a,b,c,d,e,f,g,dp}; dp always off, non-BCD codes blank.
    always_comb begin
        D_ssd = 8'b1111_1111;
        case (digit)
            4'd0:    D_ssd = 8'b0000_0011;
            4'd1:    D_ssd = 8'b1001_1111;
            4'd2:    D_ssd = 8'b0010_0101;
            4'd3:    D_ssd = 8'b0000_1101;
            4'd4:    D_ssd = 8'b1001_1001;
            4'd5:    D_ssd = 8'b0100_1001;
            4'd6:    D_ssd = 8'b0100_0001;
            4'd7:    D_ssd = 8'b0001_1111;
            4'd8:    D_ssd = 8'b0000_0001;
            4'd9:    D_ssd = 8'b0000_1001;
            default: D_ssd = 8'b1111_1111;
        endcase
    end

endmodule

// File: tb/tb_bcd_up_counter_2digit.sv
// Directed bench for bcd_up_counter_2digit with DIV_1HZ=4, SCAN_DIV=3.
module tb_bcd_up_counter_2digit;

    logic       f = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       carry;
    logic [3:0] B;
    logic [7:0] D_ssd;

    int tests = 0;
    int fails = 0;
    int n_edges = 0;

    bcd_up_counter_2digit #(.DIV_1HZ(4), .SCAN_DIV(3)) dut (
        .f(f), .rst_n(rst_n), .en(en), .clr(clr),
        .ones(ones), .tens(tens), .carry(carry), .B(B), .D_ssd(D_ssd)
    );

    always #5 f = ~f;

    // Advance n rising edges and sample 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge f);
            n_edges++;
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] seg(input int d);
        logic [7:0] t [10];
        t = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101, 8'b10011001,
              8'b01001001, 8'b01000001, 8'b00011111, 8'b00000001, 8'b00001001};
        return t[d];
    endfunction

    task automatic chk_count(input string tag, input int value);
        chk({tag, "_ones"}, {4'd0, ones}, 8'(value % 10));
        chk({tag, "_tens"}, {4'd0, tens}, 8'(value / 10));
    endtask

    task automatic release_reset();
        @(negedge f);
        rst_n   = 1'b1;
        n_edges = 0;
    endtask

    initial begin
        int cnt;
        bit sel_exp;

        // Reset held across edges
        step(2);
        chk_count("rst", 0);
        chk("rst_carry", {7'd0, carry}, 8'd0);
        chk("rst_B", {4'd0, B}, 8'b0000_1110);
        chk("rst_D", D_ssd, 8'b00000011);

        // Count rate
        release_reset();
        step(3);
        chk_count("rate_e3", 0);
        step(1);
        chk_count("rate_e4", 1);
        step(4);
        chk_count("rate_e8", 2);
        step(32);
        chk_count("rate_e40", 10);

        // Wrap: carry only right after the 59->00 edge
        for (int e = 41; e <= 244; e++) begin
            step(1);
            cnt = (e / 4) % 60;
            chk_count("wrap", cnt);
            chk("wrap_carry", {7'd0, carry}, (e == 240) ? 8'd1 : 8'd0);
        end

        // Asynchronous reset mid-period, no edge needed
        step(2);
        chk_count("pre_areset", 1);
        rst_n = 1'b0;
        #1;
        chk_count("areset", 0);
        chk("areset_carry", {7'd0, carry}, 8'd0);
        chk("areset_B", {4'd0, B}, 8'b0000_1110);
        chk("areset_D", D_ssd, 8'b00000011);
        release_reset();
        step(3);
        chk_count("restart_e3", 0);
        step(1);
        chk_count("restart_e4", 1);

        // Enable hold: freeze at pcnt=2, resume without losing the partial period
        step(2);
        en = 1'b0;
        step(10);
        chk_count("hold", 1);
        en = 1'b1;
        step(1);
        chk_count("resume_e1", 1);
        step(1);
        chk_count("resume_e2", 2);

        // Clear on the same edge as a tick at count 37
        step(140);
        step(3);
        chk_count("pre_clr", 37);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk_count("clr", 0);
        chk("clr_carry", {7'd0, carry}, 8'd0);
        step(3);
        chk_count("post_clr_e3", 0);
        step(1);
        chk_count("post_clr_e4", 1);

        // Scan at 42 with counting frozen
        step(164);
        chk_count("scan_pre", 42);
        en = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            sel_exp = ((n_edges / 3) % 2) == 1;
            chk("scan_B", {4'd0, B}, sel_exp ? 8'b0000_1101 : 8'b0000_1110);
            chk("scan_D", D_ssd, sel_exp ? seg(4) : seg(2));
        end
        chk_count("scan_hold", 42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
